// File: rtl/jtag_bitbang_bridge.sv
// Multi-chain JTAG master fed by an OpenOCD remote_bitbang byte stream.
// Define JTAG_BB_SRST_EN to let 's'/'u' drive jtag_srst_no; otherwise it is tied high.
module jtag_bitbang_bridge #(
    parameter int NumChains  = 4,
    parameter int HoldCycles = 2,
    parameter int RspDepth   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    input  logic [7:0]           cmd_data_i,
    output logic                 cmd_ready_o,
    output logic                 rsp_valid_o,
    output logic [7:0]           rsp_data_o,
    input  logic                 rsp_ready_i,
    output logic [NumChains-1:0] jtag_tck_o,
    output logic [NumChains-1:0] jtag_tms_o,
    output logic [NumChains-1:0] jtag_tdi_o,
    input  logic [NumChains-1:0] jtag_tdo_i,
    output logic                 jtag_trst_no,
    output logic                 jtag_srst_no,
    output logic                 blink_o,
    output logic                 quit_o,
    output logic                 err_o
);
    localparam int SelW = (NumChains > 1) ? $clog2(NumChains) : 1;
    localparam int HW   = (HoldCycles > 2) ? $clog2(HoldCycles) : 1;
    localparam int AW   = $clog2(RspDepth);

    typedef enum logic [1:0] {IDLE, HOLD, QUIT} state_e;

    state_e               state_q, state_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [SelW-1:0]      sel_q, sel_d;
    logic [NumChains-1:0] tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
    logic                 trst_q, trst_d, blink_q, blink_d, err_q, err_d;
    logic [AW:0]          cnt_q;
    logic [AW-1:0]        wr_q, rd_q;
    logic                 mem_q [RspDepth];
    logic                 fifo_full, accept, push, pop, go_hold;
`ifdef JTAG_BB_SRST_EN
    logic                 srst_q, srst_d;
`endif

    assign fifo_full   = (cnt_q == (AW+1)'(RspDepth));
    // A pop in the same cycle does not unblock 'R': readiness uses the registered count.
    assign cmd_ready_o = (state_q == IDLE) && !((cmd_data_i == 8'h52) && fifo_full);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign pop         = rsp_valid_o && rsp_ready_i;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        tck_d   = tck_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        trst_d  = trst_q;
        blink_d = blink_q;
        err_d   = err_q;
        push    = 1'b0;
        go_hold = 1'b0;
`ifdef JTAG_BB_SRST_EN
        srst_d  = srst_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_data_i[7]) begin
                        if (32'(cmd_data_i[6:0]) < NumChains) begin
                            sel_d = cmd_data_i[SelW-1:0];
                            tck_d = '0;
                            tms_d = '1;
                            tdi_d = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (cmd_data_i[7:3] == 5'b00110) begin
                        tck_d        = '0;
                        tms_d        = '1;
                        tdi_d        = '0;
                        tck_d[sel_q] = cmd_data_i[2];
                        tms_d[sel_q] = cmd_data_i[1];
                        tdi_d[sel_q] = cmd_data_i[0];
                        go_hold      = 1'b1;
                    end else if (cmd_data_i >= 8'h72 && cmd_data_i <= 8'h75) begin
                        // r,s,t,u: bit2 selects trst, bit0 selects srst
                        trst_d  = cmd_data_i[2];
`ifdef JTAG_BB_SRST_EN
                        srst_d  = cmd_data_i[0];
`endif
                        go_hold = 1'b1;
                    end else if (cmd_data_i == 8'h52) begin
                        push = 1'b1;
                    end else if (cmd_data_i == 8'h42) begin
                        blink_d = 1'b1;
                    end else if (cmd_data_i == 8'h62) begin
                        blink_d = 1'b0;
                    end else if (cmd_data_i == 8'h51) begin
                        state_d = QUIT;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (go_hold && HoldCycles > 1) begin
                        state_d = HOLD;
                        hold_d  = HW'(HoldCycles - 2);
                    end
                end
            end
            HOLD: begin
                if (hold_q == '0) state_d = IDLE;
                else              hold_d  = hold_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            hold_q  <= '0;
            sel_q   <= '0;
            tck_q   <= '0;
            tms_q   <= '1;
            tdi_q   <= '0;
            trst_q  <= 1'b0;
            blink_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            trst_q  <= trst_d;
            blink_q <= blink_d;
            err_q   <= err_d;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= jtag_tdo_i[sel_q];
    end

`ifdef JTAG_BB_SRST_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) srst_q <= 1'b0;
        else         srst_q <= srst_d;
    end
    assign jtag_srst_no = ~srst_q;
`else
    assign jtag_srst_no = 1'b1;
`endif

    assign rsp_valid_o  = (cnt_q != '0);
    assign rsp_data_o   = {7'b0011000, mem_q[rd_q]};
    assign jtag_tck_o   = tck_q;
    assign jtag_tms_o   = tms_q;
    assign jtag_tdi_o   = tdi_q;
    assign jtag_trst_no = ~trst_q;
    assign blink_o      = blink_q;
    assign quit_o       = (state_q == QUIT);
    assign err_o        = err_q;
endmodule

// File: tb/tb_jtag_bitbang_bridge.sv
// Scoreboard bench for jtag_bitbang_bridge (default parameters 4/2/8).
module tb_jtag_bitbang_bridge;
    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       cmd_valid_i;
    logic [7:0] cmd_data_i;
    logic       cmd_ready_o;
    logic       rsp_valid_o;
    logic [7:0] rsp_data_o;
    logic       rsp_ready_i;
    logic [3:0] jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_tdo_i;
    logic       jtag_trst_no, jtag_srst_no, blink_o, quit_o, err_o;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         sel_m = 0;
    logic       srst_on;

    jtag_bitbang_bridge #(.NumChains(4), .HoldCycles(2), .RspDepth(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_data_i(cmd_data_i), .cmd_ready_o(cmd_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_ready_i(rsp_ready_i),
        .jtag_tck_o(jtag_tck_o), .jtag_tms_o(jtag_tms_o), .jtag_tdi_o(jtag_tdi_o),
        .jtag_tdo_i(jtag_tdo_i), .jtag_trst_no(jtag_trst_no), .jtag_srst_no(jtag_srst_no),
        .blink_o(blink_o), .quit_o(quit_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns one time unit after the accepting clock edge.
    task automatic send(input logic [7:0] b);
        bit ok = 0;
        cmd_valid_i = 1'b1;
        cmd_data_i  = b;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk_i);
            if (cmd_ready_o) begin
                if (b == 8'h52) exp_q.push_back(8'h30 | {7'b0, jtag_tdo_i[sel_m]});
                if (b[7] && int'(b[6:0]) < 4) sel_m = int'(b[6:0]);
                @(posedge clk_i);
                #1;
                ok = 1;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
        cmd_valid_i = 1'b0;
    endtask

    task automatic pop_chk(input string tag);
        logic [7:0] e;
        @(negedge clk_i);
        chk({tag, "_valid"}, rsp_valid_o, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk({tag, "_data"}, rsp_data_o, e);
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b0;
    endtask

    task automatic chk_pins(input string tag, input logic [3:0] tck, input logic [3:0] tms,
                            input logic [3:0] tdi);
        chk({tag, "_tck"}, jtag_tck_o, tck);
        chk({tag, "_tms"}, jtag_tms_o, tms);
        chk({tag, "_tdi"}, jtag_tdi_o, tdi);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, cmd_ready_o, 1);
        chk({tag, "_rspv"}, rsp_valid_o, 0);
        chk_pins(tag, 4'b0000, 4'b1111, 4'b0000);
        chk({tag, "_trst"}, jtag_trst_no, 1);
        chk({tag, "_srst"}, jtag_srst_no, 1);
        chk({tag, "_flags"}, {blink_o, quit_o, err_o}, 3'b000);
    endtask

    initial begin
`ifdef JTAG_BB_SRST_EN
        srst_on = 1'b1;
`else
        srst_on = 1'b0;
`endif
        rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_data_i = 8'h00;
        rsp_ready_i = 1'b0; jtag_tdo_i = 4'b0000;
        repeat (2) @(posedge clk_i);
        #1;
        chk_reset_state("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Pin write on chain 0, then one HOLD cycle
        send(8'h36);
        chk_pins("pin6", 4'b0001, 4'b1111, 4'b0000);
        chk("hold_ready_lo", cmd_ready_o, 0);
        @(posedge clk_i);
        #1;
        chk("hold_ready_hi", cmd_ready_o, 1);

        // Select chain 2 parks chain 0; pin write; sample TDO
        send(8'h82);
        chk_pins("sel2_park", 4'b0000, 4'b1111, 4'b0000);
        send(8'h35);
        chk_pins("pin5", 4'b0100, 4'b1011, 4'b0100);
        jtag_tdo_i = 4'b0100;
        send(8'h52);
        pop_chk("rsp1");
        jtag_tdo_i = 4'b1011;
        send(8'h52);
        pop_chk("rsp0");

        // Fill the FIFO with rsp_ready low
        for (int i = 0; i < 8; i++) begin
            jtag_tdo_i = 4'($urandom_range(0, 15));
            send(8'h52);
        end
        chk("full_rspv", rsp_valid_o, 1);
        jtag_tdo_i = 4'b0100;
        cmd_valid_i = 1'b1;
        cmd_data_i  = 8'h52;
        repeat (2) begin
            @(negedge clk_i);
            chk("full_ready", cmd_ready_o, 0);
        end
        chk("pop_while_full", rsp_data_o, exp_q.pop_front());
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b0;
        @(negedge clk_i);
        chk("unblock_ready", cmd_ready_o, 1);
        exp_q.push_back(8'h31);
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) pop_chk("drain");
        @(negedge clk_i);
        chk("drained", rsp_valid_o, 0);

        // Illegal bytes set err, leave sel and pins alone
        chk("err_before", err_o, 0);
        send(8'h8F);
        chk("err_sel", err_o, 1);
        send(8'h41);
        chk_pins("err_pins", 4'b0100, 4'b1011, 4'b0100);
        send(8'h37);
        chk_pins("pin7", 4'b0100, 4'b1111, 4'b0100);
        send(8'h81);
        chk_pins("sel1_park", 4'b0000, 4'b1111, 4'b0000);
        send(8'h33);
        chk_pins("pin3", 4'b0000, 4'b1111, 4'b0010);

        // LED and resets
        send(8'h42);
        chk("blink_on", blink_o, 1);
        send(8'h62);
        chk("blink_off", blink_o, 0);
        send(8'h75);
        chk("u_trst", jtag_trst_no, 0);
        chk("u_srst", jtag_srst_no, !srst_on);
        send(8'h74);
        chk("t_trst", jtag_trst_no, 0);
        chk("t_srst", jtag_srst_no, 1);
        send(8'h73);
        chk("s_trst", jtag_trst_no, 1);
        chk("s_srst", jtag_srst_no, !srst_on);
        send(8'h72);
        chk("r_both", {jtag_trst_no, jtag_srst_no}, 2'b11);

        // Async reset mid-HOLD with a queued response and error set
        send(8'h52);
        send(8'h75);
        chk("pre_rst_hold", cmd_ready_o, 0);
        rst_ni = 1'b0;
        #1;
        chk_reset_state("midhold");
        exp_q.delete();
        sel_m = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Quit blocks all further commands
        send(8'h51);
        chk("quit", quit_o, 1);
        chk("quit_ready", cmd_ready_o, 0);
        cmd_valid_i = 1'b1;
        cmd_data_i  = 8'h37;
        repeat (3) @(posedge clk_i);
        #1;
        chk("quit_ready2", cmd_ready_o, 0);
        chk_pins("quit_pins", 4'b0000, 4'b1111, 4'b0000);
        cmd_valid_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
